// File: rtl/uart_pkg.sv
// Shared UART types and default framing constants (baud gen, tx, rx).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_tx.sv
// UART serializer: start, LSB-first data, optional parity, stop bits, paced by tick_i.
// Parity bit present only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_i,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  cfg_par_odd,
  output logic                  tx_o,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  tx_state_e             state_q;
  logic [TW-1:0]         tick_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  tx_q;
  logic                  bit_end;

`ifdef UART_TX_PARITY_EN
  logic                  par_q;
`else
  logic                  unused_cfg_par_odd;
  assign unused_cfg_par_odd = cfg_par_odd;
`endif

  assign bit_end  = tick_i && (tick_cnt_q == TICK_LAST);
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = !tx_ready;
  assign tx_o     = tx_q;
  // Flagged during the cycle whose edge ends the last stop bit, so the
  // pulse precedes tx_ready by exactly one cycle.
  assign tx_done  = (state_q == STOP) && bit_end && (bit_cnt_q == STOP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      if (tx_valid) begin
        shift_q    <= tx_data;
        state_q    <= START;
        tx_q       <= 1'b0;
        tick_cnt_q <= '0;
        bit_cnt_q  <= '0;
`ifdef UART_TX_PARITY_EN
        par_q      <= ^tx_data ^ cfg_par_odd;
`endif
      end
    end else if (tick_i) begin
      if (tick_cnt_q != TICK_LAST) begin
        tick_cnt_q <= tick_cnt_q + TICK_ONE;
      end else begin
        tick_cnt_q <= '0;
        case (state_q)
          START: begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
          end
          DATA: begin
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              tx_q      <= par_q;
`else
              state_q   <= STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
          PARITY: begin
            state_q   <= STOP;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
          end
          STOP: begin
            if (bit_cnt_q == STOP_LAST) begin
              state_q   <= IDLE;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
